// File: rtl/uart_pkg.sv
// Shared definitions for the UART command/image receive path.
package uart_pkg;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        START = 2'd1,
        DATA  = 2'd2,
        STOP  = 2'd3
    } rx_state_e;

    // Mode-select command bytes recognised by the downstream parser
    localparam logic [7:0] CMD_PC_MODE     = 8'hAA;
    localparam logic [7:0] CMD_CAMERA_MODE = 8'hBB;

endpackage

// File: rtl/sync_byte_fifo.sv
// Synchronous byte FIFO with registered read data, occupancy count and overrun flag.
module sync_byte_fifo #(
    parameter int unsigned DATA_WIDTH = 8,
    parameter int unsigned FIFO_DEPTH = 16
) (
    input  logic                          clk,
    input  logic                          reset,
    input  logic                          wr_en,
    input  logic [DATA_WIDTH-1:0]         wr_data,
    input  logic                          rd_en,
    output logic [DATA_WIDTH-1:0]         rd_data,
    output logic                          empty,
    output logic                          full,
    output logic [$clog2(FIFO_DEPTH):0]   count,
    output logic                          overrun_err
);

    localparam int unsigned PTR_W = $clog2(FIFO_DEPTH);
    localparam int unsigned CNT_W = PTR_W + 1;

    logic [DATA_WIDTH-1:0] mem_q [FIFO_DEPTH];
    logic [PTR_W-1:0]      wr_ptr_q, wr_ptr_d;
    logic [PTR_W-1:0]      rd_ptr_q, rd_ptr_d;
    logic [CNT_W-1:0]      count_q, count_d;
    logic [DATA_WIDTH-1:0] rd_data_q, rd_data_d;
    logic                  empty_q, empty_d;
    logic                  full_q, full_d;
    logic                  overrun_q, overrun_d;
    logic                  push_c, pop_c;

    // A pop frees a slot in the same cycle, so a full FIFO still accepts a push alongside it
    always_comb begin
        pop_c     = rd_en & ~empty_q;
        push_c    = wr_en & (~full_q | pop_c);
        wr_ptr_d  = wr_ptr_q;
        rd_ptr_d  = rd_ptr_q;
        count_d   = count_q;
        rd_data_d = rd_data_q;
        overrun_d = wr_en & full_q & ~pop_c;
        if (push_c) begin
            wr_ptr_d = wr_ptr_q + PTR_W'(1);
        end
        if (pop_c) begin
            rd_ptr_d  = rd_ptr_q + PTR_W'(1);
            rd_data_d = mem_q[rd_ptr_q];
        end
        case ({push_c, pop_c})
            2'b10:   count_d = count_q + CNT_W'(1);
            2'b01:   count_d = count_q - CNT_W'(1);
            default: count_d = count_q;
        endcase
        empty_d = (count_d == CNT_W'(0));
        full_d  = (count_d == CNT_W'(FIFO_DEPTH));
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            wr_ptr_q  <= '0;
            rd_ptr_q  <= '0;
            count_q   <= '0;
            rd_data_q <= '0;
            empty_q   <= 1'b1;
            full_q    <= 1'b0;
            overrun_q <= 1'b0;
        end else begin
            wr_ptr_q  <= wr_ptr_d;
            rd_ptr_q  <= rd_ptr_d;
            count_q   <= count_d;
            rd_data_q <= rd_data_d;
            empty_q   <= empty_d;
            full_q    <= full_d;
            overrun_q <= overrun_d;
        end
    end

    // Storage array carries no reset; validity is tracked by the pointers
    always_ff @(posedge clk) begin
        if (push_c) begin
            mem_q[wr_ptr_q] <= wr_data;
        end
    end

    assign rd_data     = rd_data_q;
    assign empty       = empty_q;
    assign full        = full_q;
    assign count       = count_q;
    assign overrun_err = overrun_q;

endmodule

// File: rtl/uart_rx_byte_fifo.sv
// 16x-oversampled 8N1 UART receiver feeding a synchronous byte FIFO.
module uart_rx_byte_fifo
    import uart_pkg::*;
#(
    parameter int unsigned CLK_FREQ   = 100_000_000,
    parameter int unsigned BAUD_RATE  = 115200,
    parameter int unsigned OVERSAMPLE = 16,
    parameter int unsigned DATA_WIDTH = 8,
    parameter int unsigned FIFO_DEPTH = 16
) (
    input  logic                          clk,
    input  logic                          reset,
    input  logic                          rx,
    input  logic                          rd_en,
    output logic [DATA_WIDTH-1:0]         rx_data,
    output logic                          rx_empty,
    output logic                          rx_full,
    output logic [$clog2(FIFO_DEPTH):0]   fifo_count,
    output logic                          frame_err,
    output logic                          overrun_err
);

    localparam int unsigned TICK_RAW = CLK_FREQ / (BAUD_RATE * OVERSAMPLE);
    localparam int unsigned TICK_DIV = (TICK_RAW < 1) ? 1 : TICK_RAW;
    localparam int unsigned DIV_W    = (TICK_DIV > 1) ? $clog2(TICK_DIV) : 1;
    localparam int unsigned BIT_W    = (DATA_WIDTH > 1) ? $clog2(DATA_WIDTH) : 1;

    logic                  sync1_q, sync1_d;
    logic                  rx_s_q, rx_s_d;
    logic [DIV_W-1:0]      div_cnt_q, div_cnt_d;
    logic                  tick_c;
    rx_state_e             state_q, state_d;
    logic [3:0]            tick_cnt_q, tick_cnt_d;
    logic [BIT_W-1:0]      bit_idx_q, bit_idx_d;
    logic [DATA_WIDTH-1:0] shift_q, shift_d;
    logic                  frame_err_q, frame_err_d;
    logic                  byte_done_c;

    // Synchroniser, oversample tick divider and receive FSM next-state
    always_comb begin
        sync1_d     = rx;
        rx_s_d      = sync1_q;
        tick_c      = (div_cnt_q == DIV_W'(TICK_DIV - 1));
        div_cnt_d   = tick_c ? '0 : div_cnt_q + DIV_W'(1);
        state_d     = state_q;
        tick_cnt_d  = tick_cnt_q;
        bit_idx_d   = bit_idx_q;
        shift_d     = shift_q;
        frame_err_d = 1'b0;
        byte_done_c = 1'b0;
        if (tick_c) begin
            case (state_q)
                IDLE: begin
                    if (!rx_s_q) begin
                        state_d    = START;
                        tick_cnt_d = 4'd0;
                    end
                end
                START: begin
                    if (tick_cnt_q == 4'd7) begin
                        if (!rx_s_q) begin
                            state_d    = DATA;
                            tick_cnt_d = 4'd0;
                            bit_idx_d  = '0;
                        end else begin
                            state_d = IDLE;
                        end
                    end else begin
                        tick_cnt_d = tick_cnt_q + 4'd1;
                    end
                end
                DATA: begin
                    // 4-bit counter wraps 15 -> 0 into the next bit period
                    tick_cnt_d = tick_cnt_q + 4'd1;
                    if (tick_cnt_q == 4'd15) begin
                        shift_d = {rx_s_q, shift_q[DATA_WIDTH-1:1]};
                        if (bit_idx_q == BIT_W'(DATA_WIDTH - 1)) begin
                            state_d = STOP;
                        end else begin
                            bit_idx_d = bit_idx_q + BIT_W'(1);
                        end
                    end
                end
                STOP: begin
                    tick_cnt_d = tick_cnt_q + 4'd1;
                    if (tick_cnt_q == 4'd15) begin
                        state_d     = IDLE;
                        byte_done_c = rx_s_q;
                        frame_err_d = ~rx_s_q;
                    end
                end
                default: state_d = IDLE;
            endcase
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            sync1_q     <= 1'b1;
            rx_s_q      <= 1'b1;
            div_cnt_q   <= '0;
            state_q     <= IDLE;
            tick_cnt_q  <= 4'd0;
            bit_idx_q   <= '0;
            shift_q     <= '0;
            frame_err_q <= 1'b0;
        end else begin
            sync1_q     <= sync1_d;
            rx_s_q      <= rx_s_d;
            div_cnt_q   <= div_cnt_d;
            state_q     <= state_d;
            tick_cnt_q  <= tick_cnt_d;
            bit_idx_q   <= bit_idx_d;
            shift_q     <= shift_d;
            frame_err_q <= frame_err_d;
        end
    end

    assign frame_err = frame_err_q;

    sync_byte_fifo #(
        .DATA_WIDTH (DATA_WIDTH),
        .FIFO_DEPTH (FIFO_DEPTH)
    ) u_fifo (
        .clk         (clk),
        .reset       (reset),
        .wr_en       (byte_done_c),
        .wr_data     (shift_q),
        .rd_en       (rd_en),
        .rd_data     (rx_data),
        .empty       (rx_empty),
        .full        (rx_full),
        .count       (fifo_count),
        .overrun_err (overrun_err)
    );

endmodule

// File: tb/tb_uart_rx_byte_fifo.sv
// Scoreboard bench: serial frames driven at 16 clk/bit, popped bytes compared against a queue.
module tb_uart_rx_byte_fifo;
    import uart_pkg::*;

    localparam int unsigned DW    = 8;
    localparam int unsigned DEPTH = 16;
    localparam int          NO_POP = 100000;

    logic          clk = 1'b0;
    logic          reset;
    logic          rx;
    logic          rd_en;
    logic [DW-1:0] rx_data;
    logic          rx_empty;
    logic          rx_full;
    logic [4:0]    fifo_count;
    logic          frame_err;
    logic          overrun_err;

    int            n_checks = 0;
    int            n_fail = 0;
    int            fe_cnt = 0;
    int            ov_cnt = 0;
    logic [7:0]    exp_q[$];
    logic [7:0]    last_data;
    int            fe_base;
    int            ov_base;

    uart_rx_byte_fifo #(
        .CLK_FREQ   (1_600_000),
        .BAUD_RATE  (100_000),
        .OVERSAMPLE (16),
        .DATA_WIDTH (DW),
        .FIFO_DEPTH (DEPTH)
    ) dut (
        .clk         (clk),
        .reset       (reset),
        .rx          (rx),
        .rd_en       (rd_en),
        .rx_data     (rx_data),
        .rx_empty    (rx_empty),
        .rx_full     (rx_full),
        .fifo_count  (fifo_count),
        .frame_err   (frame_err),
        .overrun_err (overrun_err)
    );

    always #5 clk = ~clk;

    // Error pulses are sampled once per cycle on the falling edge
    always @(negedge clk) begin
        if (frame_err)   fe_cnt++;
        if (overrun_err) ov_cnt++;
    end

    task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s got=0x%0h exp=0x%0h", tag, got, exp);
        end
    endtask

    // Expected popped byte: queue head, or the held value when the FIFO was empty
    task automatic check_pop(input string tag);
        logic [7:0] e;
        if (exp_q.size() > 0) begin
            e = exp_q.pop_front();
            last_data = e;
        end else begin
            e = last_data;
        end
        check_eq(tag, 32'(rx_data), 32'(e));
    endtask

    task automatic do_pop(input string tag);
        rd_en = 1'b1;
        @(negedge clk);
        rd_en = 1'b0;
        check_pop(tag);
    endtask

    // One 8N1 frame, 16 clk per bit; optionally one rd_en pulse at frame cycle pop_at
    task automatic send_frame(input logic [7:0] b, input logic stop_bit, input int pop_at);
        logic [9:0] bits;
        bits = {stop_bit, b, 1'b0};
        for (int k = 0; k < 160; k++) begin
            if (k == pop_at + 1) begin
                rd_en = 1'b0;
                check_pop("pop_during_push");
            end
            rx = bits[k / 16];
            if (k == pop_at) rd_en = 1'b1;
            @(negedge clk);
        end
        rx = 1'b1;
    endtask

    task automatic send_good(input logic [7:0] b);
        exp_q.push_back(b);
        send_frame(b, 1'b1, NO_POP);
    endtask

    initial begin
        #1_000_000;
        $display("FAIL watchdog got=timeout exp=finish");
        $fatal(1, "watchdog expired");
    end

    initial begin
        logic [7:0]  partial;
        logic [9:0]  pbits;
        reset = 1'b1;
        rx    = 1'b1;
        rd_en = 1'b0;
        last_data = 8'h00;
        repeat (3) @(negedge clk);
        reset = 1'b0;

        check_eq("rst_rx_data",  32'(rx_data),     32'h0);
        check_eq("rst_empty",    32'(rx_empty),    32'h1);
        check_eq("rst_full",     32'(rx_full),     32'h0);
        check_eq("rst_count",    32'(fifo_count),  32'h0);
        check_eq("rst_frame",    32'(frame_err),   32'h0);
        check_eq("rst_overrun",  32'(overrun_err), 32'h0);
        repeat (5) @(negedge clk);

        // Single command byte
        send_good(CMD_PC_MODE);
        check_eq("t1_empty_low", 32'(rx_empty),   32'h0);
        check_eq("t1_count",     32'(fifo_count), 32'h1);
        do_pop("t1_data");
        check_eq("t1_empty_after", 32'(rx_empty), 32'h1);

        // Back-to-back frames, then a pop while empty
        send_good(8'h55);
        send_good(8'hBB);
        send_good(8'h00);
        check_eq("t2_count", 32'(fifo_count), 32'h3);
        for (int i = 0; i < 4; i++) do_pop("t2_data");
        check_eq("t2_empty", 32'(rx_empty), 32'h1);

        // Short low glitch on the line is rejected silently
        fe_base = fe_cnt;
        rx = 1'b0;
        repeat (4) @(negedge clk);
        rx = 1'b1;
        repeat (40) @(negedge clk);
        check_eq("t3_count", 32'(fifo_count), 32'h0);
        check_eq("t3_frame", 32'(fe_cnt - fe_base), 32'h0);
        send_good(CMD_CAMERA_MODE);
        do_pop("t3_after_glitch");

        // Bad stop bit
        fe_base = fe_cnt;
        send_frame(8'h3C, 1'b0, NO_POP);
        repeat (40) @(negedge clk);
        check_eq("t4_frame_pulses", 32'(fe_cnt - fe_base), 32'h1);
        check_eq("t4_count", 32'(fifo_count), 32'h0);
        check_eq("t4_empty", 32'(rx_empty), 32'h1);

        // Fill to full, then one byte too many
        for (int i = 0; i < 16; i++) send_good(8'(i));
        check_eq("t5_full",  32'(rx_full),    32'h1);
        check_eq("t5_count", 32'(fifo_count), 32'h10);
        ov_base = ov_cnt;
        send_frame(8'hFF, 1'b1, NO_POP);
        check_eq("t5_overrun", 32'(ov_cnt - ov_base), 32'h1);
        check_eq("t5_count_ovr", 32'(fifo_count), 32'h10);
        for (int i = 0; i < 16; i++) do_pop("t5_drain");
        check_eq("t5_empty", 32'(rx_empty), 32'h1);

        // Full again; pop lands on the stop-bit sample cycle of the 17th frame
        for (int i = 0; i < 16; i++) send_good(8'(i));
        ov_base = ov_cnt;
        exp_q.push_back(8'hFF);
        send_frame(8'hFF, 1'b1, 154);
        check_eq("t5b_no_overrun", 32'(ov_cnt - ov_base), 32'h0);
        check_eq("t5b_count", 32'(fifo_count), 32'h10);
        check_eq("t5b_full",  32'(rx_full),    32'h1);
        for (int i = 0; i < 16; i++) do_pop("t5b_drain");
        check_eq("t5b_empty", 32'(rx_empty), 32'h1);

        // Reset in the middle of a frame with data already stored
        send_good(8'h11);
        partial = 8'h12;
        pbits = {1'b1, partial, 1'b0};
        for (int k = 0; k < 64; k++) begin
            rx = pbits[k / 16];
            @(negedge clk);
        end
        reset = 1'b1;
        rx    = 1'b1;
        @(negedge clk);
        reset = 1'b0;
        exp_q.delete();
        last_data = 8'h00;
        check_eq("t6_empty",   32'(rx_empty),   32'h1);
        check_eq("t6_count",   32'(fifo_count), 32'h0);
        check_eq("t6_rx_data", 32'(rx_data),    32'h0);
        repeat (20) @(negedge clk);
        send_good(8'h7E);
        check_eq("t6_count_new", 32'(fifo_count), 32'h1);
        do_pop("t6_data");

        $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
        $finish;
    end

endmodule
